// File: rtl/img_stream_pkg.sv
// Shared image-stream definitions: frame reader FSM states, default pixel
// width and line/row position counter width.
package img_stream_pkg;

  localparam int PIX_W = 16;
  localparam int POS_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } frame_state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry skid buffer. The ready and valid outputs depend only on the
// registered occupancy count, so out_ready has no combinational path
// through to in_ready.
module stream_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign empty     = (count == 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage, pointers and occupancy; mem is cleared so outputs read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Frame reader: pops H_ACTIVE x V_ACTIVE pixels from a show-ahead line FIFO
// per start pulse and streams them out with sof/eol tags through a skid buffer.
// Optional feature: define FIFO_FRAME_READER_STATS_EN to add underrun_cnt,
// a saturating count of RUN cycles spent waiting on an empty FIFO.
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | popping pixels from the FIFO
//   DRAIN | all pixels popped, waiting for the skid buffer to empty
module fifo_frame_reader
  import img_stream_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fifo_rd_vld,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol,
  output logic              busy,
  output logic              frame_done
`ifdef FIFO_FRAME_READER_STATS_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam logic [POS_W-1:0] COL_LAST = POS_W'(H_ACTIVE - 1);
  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(V_ACTIVE - 1);

  frame_state_e       state;
  frame_state_e       state_nxt;
  logic [POS_W-1:0]   col;
  logic [POS_W-1:0]   row;
  logic               start_acc;
  logic               last_pop;
  logic               buf_ready;
  logic               buf_empty;
  logic               pix_sof;
  logic               pix_eol;
  logic [DATA_W+1:0]  buf_out;

  assign start_acc  = (state == IDLE) && start;
  assign fifo_rd_en = (state == RUN) && fifo_rd_vld && buf_ready;
  assign last_pop   = fifo_rd_en && (col == COL_LAST) && (row == ROW_LAST);
  assign pix_sof    = (col == '0) && (row == '0);
  assign pix_eol    = (col == COL_LAST);
  assign busy       = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; frame_done fires on the cycle DRAIN sees an empty buffer.
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (last_pop) state_nxt = DRAIN;
      DRAIN: begin
        if (buf_empty) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel position; only advances on a pop so FIFO stalls keep the position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start_acc) begin
      col <= '0;
      row <= '0;
    end else if (fifo_rd_en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef FIFO_FRAME_READER_STATS_EN
  // Saturating count of RUN cycles with no FIFO data available.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (start_acc) begin
      underrun_cnt <= '0;
    end else if ((state == RUN) && !fifo_rd_vld && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

  stream_skid_buf #(
    .W(DATA_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fifo_rd_en),
    .in_data   ({pix_sof, pix_eol, fifo_rd_data}),
    .in_ready  (buf_ready),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (buf_out),
    .empty     (buf_empty)
  );

  assign m_sof  = buf_out[DATA_W+1];
  assign m_eol  = buf_out[DATA_W];
  assign m_data = buf_out[DATA_W-1:0];

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Self-checking bench for fifo_frame_reader with a 4x2 frame. The FIFO and
// the expected pixel stream are modelled with a queue and plain arithmetic.
module tb_fifo_frame_reader;

  localparam int DW   = 16;
  localparam int H    = 4;
  localparam int V    = 2;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          fifo_rd_vld = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          busy;
  logic          frame_done;
`ifdef FIFO_FRAME_READER_STATS_EN
  logic [15:0]   underrun_cnt;
`endif

  fifo_frame_reader #(
    .DATA_W   (DW),
    .H_ACTIVE (H),
    .V_ACTIVE (V)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sof        (m_sof),
    .m_eol        (m_eol),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef FIFO_FRAME_READER_STATS_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] fq[$];

  typedef struct {
    int ready_mode;   // 0: always ready, 1: toggle, 2: random
    int stall_after;  // pop count after which fifo_rd_vld drops (-1: never)
    int stall_len;
    int vld_rand;     // 1: random FIFO-empty cycles
    int start_at;     // cycle of an extra start pulse during the frame (-1: none)
    int reset_after;  // accepted pixels before rst_n is pulled (-1: none)
    int exp_span;     // cycles from first to last accepted pixel (-1: don't care)
    int exp_under;    // expected underrun count (-1: use model)
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero();
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_sof", 32'(m_sof), 0);
    chk("rst_m_eol", 32'(m_eol), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
`ifdef FIFO_FRAME_READER_STATS_EN
    chk("rst_underrun_cnt", 32'(underrun_cnt), 0);
`endif
  endtask

  task automatic run_frame(input vec_t v);
    int cyc, acc, pops, occ, stall_left, under_m;
    int first_acc, last_acc, done_cyc, done_cnt;
    bit run_flag, pop_pend, hold, lat_pend, blocked, rst_req;
    logic [DW+1:0] held;
    acc = 0; pops = 0; occ = 0; stall_left = 0; under_m = 0;
    first_acc = -1; last_acc = -1; done_cyc = -1; done_cnt = 0;
    run_flag = 0; pop_pend = 0; hold = 0; lat_pend = 0; rst_req = 0;
    held = '0;
    fq.delete();
    for (int i = 0; i < NPIX + 2; i++) fq.push_back(DW'(i + 1));
    for (cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        void'(fq.pop_front());
        pop_pend = 0;
      end
      start = (cyc == 0) || (cyc == v.start_at);
      case (v.ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      blocked = 0;
      if (stall_left > 0) begin
        blocked = 1;
        stall_left--;
      end else if (v.vld_rand != 0 && $urandom_range(0, 3) == 0) begin
        blocked = 1;
      end
      fifo_rd_vld  = !blocked && (fq.size() > 0);
      fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
      if (rst_req) begin
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_all_zero();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fifo_rd_vld = 1'b0;
        return;
      end
      @(negedge clk);
      chk("rd_en_without_vld", 32'(fifo_rd_en & ~fifo_rd_vld), 0);
      if (occ == 2) chk("pop_when_full", 32'(fifo_rd_en), 0);
      if (pops == NPIX) chk("pop_after_frame", 32'(fifo_rd_en), 0);
      if (hold) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_stable", 32'({m_sof, m_eol, m_data}), 32'(held));
      end
      if (lat_pend) chk("pop_to_valid_latency", 32'(m_valid), 1);
      if (run_flag && !fifo_rd_vld) under_m++;
      if (cyc == 0) run_flag = 1;
      lat_pend = fifo_rd_en && (occ == 0);
      if (m_valid && m_ready) begin
        chk("pix_data", 32'(m_data), 32'(acc + 1));
        chk("pix_sof", 32'(m_sof), 32'(acc == 0));
        chk("pix_eol", 32'(m_eol), 32'(acc % H == H - 1));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        acc++;
        occ--;
      end
      if (fifo_rd_en) begin
        pops++;
        occ++;
        pop_pend = 1;
        if (pops == v.stall_after) stall_left = v.stall_len;
        if (pops == NPIX) run_flag = 0;
      end
      hold = m_valid && !m_ready;
      held = {m_sof, m_eol, m_data};
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (v.reset_after >= 0 && acc == v.reset_after) rst_req = 1;
      if (done_cyc >= 0 && cyc >= done_cyc + 5) break;
    end
    start = 1'b0;
    chk("pixel_count", 32'(acc), NPIX);
    chk("pop_count", 32'(pops), NPIX);
    chk("frame_done_count", 32'(done_cnt), 1);
    chk("frame_done_timing", 32'(done_cyc), 32'(last_acc + 1));
    chk("busy_after_frame", 32'(busy), 0);
    if (v.exp_span >= 0) chk("output_span", 32'(last_acc - first_acc), 32'(v.exp_span));
    if (v.exp_under >= 0) chk("model_underrun", 32'(under_m), 32'(v.exp_under));
`ifdef FIFO_FRAME_READER_STATS_EN
    chk("underrun_cnt", 32'(underrun_cnt), 32'(under_m));
`endif
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{0, -1, 0, 0, -1, -1, 7, 0};   // full-rate frame
    tbl[1] = '{1, -1, 0, 0, -1, -1, -1, 0};  // m_ready toggling
    tbl[2] = '{0, 3, 5, 0, -1, -1, 12, 5};   // 5-cycle FIFO empty after word 3
    tbl[3] = '{0, -1, 0, 0, 4, -1, 7, 0};    // start pulsed during RUN
    tbl[4] = '{0, -1, 0, 0, -1, 5, -1, -1};  // reset after word 5
    tbl[5] = '{0, -1, 0, 0, -1, -1, 7, 0};   // fresh frame after reset
    tbl[6] = '{2, -1, 0, 1, -1, -1, -1, -1}; // random backpressure and stalls
    tbl[7] = '{2, -1, 0, 1, 9, -1, -1, -1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
